// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide, one bit per clock, with a sign-fix cycle before results are published.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state, w_next;
    logic             r_op, r_a_neg, r_b_neg;
    logic [WIDTH-1:0] r_m;
    logic [2*WIDTH:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             w_load, w_iter, w_fix, w_dz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (op && b_in == '0) ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load = (r_state == S_IDLE) && start;
        w_iter = (r_state == S_CALC);
        w_fix  = (r_state == S_FIX);
        w_dz   = w_load && op && (b_in == '0);
    end

    logic [WIDTH-1:0] w_a_abs, w_b_abs;
    assign w_a_abs = a_in[WIDTH-1] ? -a_in : a_in;
    assign w_b_abs = b_in[WIDTH-1] ? -b_in : b_in;

    // Booth step: add in WIDTH+1 bits so M = INT_MIN cannot overflow before the shift
    logic [WIDTH:0]   w_bsum;
    logic [2*WIDTH:0] w_booth_nx;
    always_comb begin
        case (r_acc[1:0])
            2'b01:   w_bsum = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]} + {r_m[WIDTH-1], r_m};
            2'b10:   w_bsum = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]} - {r_m[WIDTH-1], r_m};
            default: w_bsum = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
        endcase
    end
    assign w_booth_nx = {w_bsum, r_acc[WIDTH:1]};

    // Restoring divide: remainder in r_acc[2W:W], quotient shifts in at r_acc[W-1:0]
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic [2*WIDTH:0] w_div_nx;
    assign w_shift  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_m};
    assign w_div_nx = w_diff[WIDTH+1] ? {w_shift, r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH:0], r_acc[WIDTH-2:0], 1'b1};

    logic [WIDTH-1:0] w_q, w_r, w_q_fix, w_r_fix;
    assign w_q     = r_acc[WIDTH-1:0];
    assign w_r     = r_acc[2*WIDTH-1:WIDTH];
    assign w_q_fix = (r_a_neg ^ r_b_neg) ? -w_q : w_q;
    assign w_r_fix = r_a_neg ? -w_r : w_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_m      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= w_fix;
            if (w_load) begin
                r_op     <= op;
                r_a_neg  <= a_in[WIDTH-1];
                r_b_neg  <= b_in[WIDTH-1];
                r_cnt    <= '0;
                busy     <= 1'b1;
                div_zero <= w_dz;
                if (op) begin
                    r_m   <= w_b_abs;
                    r_acc <= {{(WIDTH+1){1'b0}}, w_a_abs};
                end else begin
                    r_m   <= a_in;
                    r_acc <= {{WIDTH{1'b0}}, b_in, 1'b0};
                end
            end else if (w_iter) begin
                r_acc <= r_op ? w_div_nx : w_booth_nx;
                r_cnt <= r_cnt + 1'b1;
            end else if (w_fix) begin
                busy <= 1'b0;
                if (!div_zero) begin
                    if (r_op) begin
                        hi_out <= w_r_fix;
                        lo_out <= w_q_fix;
                    end else begin
                        hi_out <= r_acc[2*WIDTH:WIDTH+1];
                        lo_out <= r_acc[WIDTH:1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus divide-by-zero,
// mid-operation reset and start-while-busy sequences.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a_in, b_in, hi_out, lo_out;
    logic         busy, done, div_zero;

    int n_chk = 0;
    int n_err = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a_in = $urandom; b_in = $urandom;
        check("done_low_after_accept", {31'b0, done}, 32'd0);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            start = (pulse_at != 0 && lat == pulse_at);
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    task automatic check_res(input string tag, input vec_t v, input int lat, input int bcnt);
        check({tag, "_lat"},  32'(lat),  32'(v.lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(v.lat));
        check({tag, "_hi"},   hi_out,    v.hi);
        check({tag, "_lo"},   lo_out,    v.lo);
        check({tag, "_dz"},   {31'b0, div_zero}, {31'b0, v.dz});
    endtask

    initial begin
        int   lat, bcnt, seen;
        vec_t v;

        //            op    a             b             hi            lo            dz    lat
        vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[2]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[3]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        vecs[5]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[6]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, 33};
        vecs[7]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0, 33};
        vecs[8]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
        vecs[9]  = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};
        vecs[10] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
        vecs[11] = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
        vecs[12] = '{1'b1, 32'd3,        32'd5,        32'd3,        32'd0,        1'b0, 33};
        vecs[13] = '{1'b1, 32'd5,        32'd2,        32'd1,        32'd2,        1'b0, 33};

        reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dz",   {31'b0, div_zero}, 32'd0);
        check("rst_hi",   hi_out, 32'd0);
        check("rst_lo",   lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back: each start lands in the cycle the previous done is high
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, bcnt);
            check_res($sformatf("vec%0d", i), vecs[i], lat, bcnt);
        end

        // Divide by zero holds hi=1/lo=2 from vec13, then a multiply clears the flag
        v = '{1'b1, 32'd5, 32'd0, 32'd1, 32'd2, 1'b1, 1};
        do_op(v.op, v.a, v.b, 0, lat, bcnt);
        check_res("divzero", v, lat, bcnt);
        v = '{1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33};
        do_op(v.op, v.a, v.b, 0, lat, bcnt);
        check_res("mul_after_dz", v, lat, bcnt);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd1234; b_in = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_hi",   hi_out, 32'd0);
        check("midrst_lo",   lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        check("midrst_idle_busy", {31'b0, busy}, 32'd0);

        // A second start during a running divide is ignored
        v = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
        do_op(v.op, v.a, v.b, 5, lat, bcnt);
        check_res("start_busy", v, lat, bcnt);
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("no_requeue_busy", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the datapath's mult/div instructions.
- Consumes the A and B operand registers; control unit pulses start and stalls until done.
- Produces HI/LO results feeding the memToReg write-back mux (mfhi/mflo paths).
- Shift-add iterative design, one bit per cycle, no combinational 32x32 multiplier.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  1  0 = signed multiply, 1 = signed divide
- a_in  input  WIDTH  multiplicand / dividend (from A register)
- b_in  input  WIDTH  multiplier / divisor (from B register)
- hi_out  output  WIDTH  mult: upper product half; div: remainder
- lo_out  output  WIDTH  mult: lower product half; div: quotient
- busy  output  1  high while an operation is in flight
- done  output  1  single-cycle completion pulse
- div_zero  output  1  sticky flag: last accepted divide had b_in = 0

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; hi_out, lo_out, internal accumulators and counter all 0; busy = 0, done = 0, div_zero = 0. Reset mid-operation aborts it; no partial result reaches hi_out/lo_out.
- States: IDLE, CALC, FIX.
- IDLE: at an edge with start = 1:
  - Latch op, a_in, b_in; clear the iteration counter; set busy = 1; clear div_zero.
  - If op = 1 and b_in = 0: set div_zero = 1 and go to FIX, skipping CALC.
  - Otherwise go to CALC.
- CALC: one iteration per edge; the counter increments; after iteration WIDTH-1 go to FIX.
  - Multiply: radix-2 Booth on a 2*WIDTH+1-bit accumulator, arithmetic right shift each iteration.
  - Divide: restoring division on the operand magnitudes; record the dividend and divisor signs at load.
- FIX: one edge.
  - Multiply: hi_out/lo_out take the 2*WIDTH-bit two's-complement product.
  - Divide: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Divide by zero: hi_out/lo_out hold their previous values.
  - done = 1 for exactly this following cycle; busy = 0; return to IDLE.
- Latency: if start is sampled at edge N, done is high in the cycle after edge N+WIDTH+1 (34 edges for WIDTH = 32). A divide-by-zero completes after edge N+1.
- start while busy = 1 is ignored, not queued. start in the same cycle that done is high is accepted (state is IDLE).
- hi_out/lo_out are stable from done until the next completed operation. Operand inputs may change freely after the accept edge.
- Overflow wrap cases:
  - INT_MIN / -1: lo_out = 0x80000000, hi_out = 0, div_zero = 0.
  - INT_MIN * INT_MIN: hi = 0x40000000, lo = 0.
- div_zero persists until the next accepted start.

Test Plan:
- Multiply 7 * -3 (a = 0x00000007, b = 0xFFFFFFFD): done after 34 edges -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high 33 cycles; done high exactly 1 cycle.
- Divide -7 / 2 (a = 0xFFFFFFF9, b = 0x00000002) -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), div_zero = 0.
- Divide 5 / 0 after a prior result of hi = 0x1, lo = 0x2 -> done after 2 edges, div_zero = 1, hi/lo stay 0x1/0x2; next multiply 2 * 3 clears div_zero, lo = 6, hi = 0.
- Corner values:
  - 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
  - 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
- Reset mid-op: start a multiply, drive reset = 0 asynchronously at cycle 10 -> busy, done, hi and lo go to 0 immediately, with no done pulse afterwards. Then start while busy: a second start pulse at cycle 5 of a running divide changes neither the result nor the timing.
